// File: rtl/rle_pkg.sv
// Shared definitions for the RLE bit decompressor: FSM state encoding,
// token field positions and the end-of-stream run value.
// Optional feature macro used by the top: RLE_WORD_COUNT_EN.
package rle_pkg;

    // Default geometry; instances may override through parameters.
    localparam int CNT_W_DEFAULT  = 7;
    localparam int WORD_W_DEFAULT = 8;

    // Run field occupies [CNT_W-1:0] starting here; value bit sits just above it.
    localparam int TOK_RUN_LSB = 0;

    // A token whose run field equals this value terminates the stream.
    localparam int END_TOKEN_RUN = 0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_EXPAND = 3'd2,
        S_EMIT   = 3'd3,
        S_FLUSH  = 3'd4,
        S_DONE   = 3'd5
    } rle_state_e;

    // Index of the value bit inside a token for a given run-field width.
    function automatic int tok_value_idx(input int cnt_w);
        return cnt_w;
    endfunction

endpackage

// File: rtl/rle_bit_decompressor_if.sv
// Token-in / word-out stream interface of the RLE bit decompressor.
// Handshake rule for both directions: a transfer happens on a rising clock
// edge where valid and ready are both high; the producer keeps valid and its
// payload stable until that edge, and ready never depends on the same-cycle
// valid of the other side.
interface rle_bit_decompressor_if #(
    parameter int CNT_W  = 7,
    parameter int WORD_W = 8
);
    localparam int TOK_W = CNT_W + 1;

    logic              In_Valid;
    logic [TOK_W-1:0]  In_Token;
    logic              In_Ready;
    logic              Out_Valid;
    logic [WORD_W-1:0] Out_Data;
    logic              Out_Ready;

    // Environment side: supplies tokens, consumes words.
    modport master (
        output In_Valid,
        output In_Token,
        input  In_Ready,
        input  Out_Valid,
        input  Out_Data,
        output Out_Ready
    );

    // Decompressor side.
    modport slave (
        input  In_Valid,
        input  In_Token,
        output In_Ready,
        output Out_Valid,
        output Out_Data,
        input  Out_Ready
    );
endinterface

// File: rtl/rle_bit_packer.sv
// LSB-first bit packer: writes one bit per cycle at bit_idx into a word
// register. Clear has priority over write. o_last flags that the next
// write lands in the top bit; o_empty flags that nothing has been written.
module rle_bit_packer #(
    parameter int WORD_W = 8
) (
    input  logic              Clk,
    input  logic              Rst_N,
    input  logic              i_bit,
    input  logic              i_write,
    input  logic              i_clear,
    output logic [WORD_W-1:0] o_word,
    output logic              o_last,
    output logic              o_empty
);
    localparam int IDX_W = $clog2(WORD_W);

    logic [WORD_W-1:0] r_word;
    logic [IDX_W-1:0]  r_bit_idx;

    // Word register and write pointer; the pointer wraps after the top bit
    // so the held word stays intact until the owner clears it.
    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            r_word    <= '0;
            r_bit_idx <= '0;
        end else if (i_clear) begin
            r_word    <= '0;
            r_bit_idx <= '0;
        end else if (i_write) begin
            r_word[r_bit_idx] <= i_bit;
            if (r_bit_idx == IDX_W'(WORD_W - 1)) begin
                r_bit_idx <= '0;
            end else begin
                r_bit_idx <= r_bit_idx + IDX_W'(1);
            end
        end
    end

    assign o_word  = r_word;
    assign o_last  = (r_bit_idx == IDX_W'(WORD_W - 1));
    assign o_empty = (r_bit_idx == '0);

endmodule

// File: rtl/rle_bit_decompressor.sv
// Run-length bit decoder: accepts {value, run} tokens and emits the expanded
// bit stream packed LSB-first into WORD_W-bit words, one bit per clock.
// A token with run==0 ends the stream; a partially filled word is flushed
// with zero upper bits.
// Optional feature macro: RLE_WORD_COUNT_EN adds a saturating 16-bit count
// of accepted output words (Word_Count).
module rle_bit_decompressor
    import rle_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEFAULT,
    parameter int WORD_W = WORD_W_DEFAULT
) (
    input  logic                 Clk,
    input  logic                 Rst_N,
    input  logic                 Start,
    rle_bit_decompressor_if.slave bus,
    output logic                 Busy,
    output logic                 Done,
`ifdef RLE_WORD_COUNT_EN
    output logic [15:0]          Word_Count,
`endif
    output rle_state_e           Dbg_State
);
    localparam int VAL_IDX = tok_value_idx(CNT_W);

    rle_state_e        r_state;
    rle_state_e        w_next_state;
    logic              r_value;
    logic              w_value_next;
    logic [CNT_W-1:0]  r_run_left;
    logic [CNT_W-1:0]  w_run_left_next;

    logic              w_tok_value;
    logic [CNT_W-1:0]  w_tok_run;
    logic              w_pk_write;
    logic              w_pk_clear;
    logic [WORD_W-1:0] w_pk_word;
    logic              w_pk_last;
    logic              w_pk_empty;
    logic              w_out_fire;

    assign w_tok_value = bus.In_Token[VAL_IDX];
    assign w_tok_run   = bus.In_Token[TOK_RUN_LSB +: CNT_W];

    rle_bit_packer #(
        .WORD_W (WORD_W)
    ) u_packer (
        .Clk     (Clk),
        .Rst_N   (Rst_N),
        .i_bit   (r_value),
        .i_write (w_pk_write),
        .i_clear (w_pk_clear),
        .o_word  (w_pk_word),
        .o_last  (w_pk_last),
        .o_empty (w_pk_empty)
    );

    // State, current bit value and remaining run length.
    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            r_state    <= S_IDLE;
            r_value    <= 1'b0;
            r_run_left <= '0;
        end else begin
            r_state    <= w_next_state;
            r_value    <= w_value_next;
            r_run_left <= w_run_left_next;
        end
    end

    // Next state, run bookkeeping and packer control.
    always_comb begin
        w_next_state    = r_state;
        w_value_next    = r_value;
        w_run_left_next = r_run_left;
        w_pk_write      = 1'b0;
        w_pk_clear      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_pk_clear   = 1'b1;
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                if (bus.In_Valid) begin
                    if (w_tok_run == CNT_W'(END_TOKEN_RUN)) begin
                        w_next_state = S_FLUSH;
                    end else begin
                        w_value_next    = w_tok_value;
                        w_run_left_next = w_tok_run;
                        w_next_state    = S_EXPAND;
                    end
                end
            end
            S_EXPAND: begin
                w_pk_write      = 1'b1;
                w_run_left_next = r_run_left - CNT_W'(1);
                // A full word wins over an exhausted run; EMIT then returns
                // to LOAD because run_left is already zero.
                if (w_pk_last) begin
                    w_next_state = S_EMIT;
                end else if (r_run_left == CNT_W'(1)) begin
                    w_next_state = S_LOAD;
                end
            end
            S_EMIT: begin
                if (bus.Out_Ready) begin
                    w_pk_clear   = 1'b1;
                    w_next_state = (r_run_left != '0) ? S_EXPAND : S_LOAD;
                end
            end
            S_FLUSH: begin
                if (w_pk_empty) begin
                    w_next_state = S_DONE;
                end else if (bus.Out_Ready) begin
                    w_pk_clear   = 1'b1;
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign bus.In_Ready  = (r_state == S_LOAD);
    assign bus.Out_Valid = (r_state == S_EMIT) || ((r_state == S_FLUSH) && !w_pk_empty);
    assign bus.Out_Data  = w_pk_word;
    assign Busy          = (r_state != S_IDLE);
    assign Done          = (r_state == S_DONE);
    assign Dbg_State     = r_state;
    assign w_out_fire    = bus.Out_Valid && bus.Out_Ready;

`ifdef RLE_WORD_COUNT_EN
    logic [15:0] r_word_count;

    // Words handed to the consumer since the last honoured Start, saturating.
    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            r_word_count <= '0;
        end else if ((r_state == S_IDLE) && Start) begin
            r_word_count <= '0;
        end else if (w_out_fire && (r_word_count != 16'hFFFF)) begin
            r_word_count <= r_word_count + 16'd1;
        end
    end

    assign Word_Count = r_word_count;
`else
    logic w_unused_fire;
    assign w_unused_fire = w_out_fire;
`endif

endmodule
